// File: rtl/snn_rx_loader.sv
// Loads one binary image from the UART byte stream into the SNN pixel RAM, one pixel per cycle.
// After the last byte it pulses start to the core, then waits for done before taking the next image.
module snn_rx_loader #(
  parameter int unsigned NUM_BYTES = 98,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              start,
  output logic              loading,
  output logic              ovr_err
);

  localparam int unsigned BC_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT,
    S_START,
    S_RUN
  } state_t;

  state_t          state;
  logic [7:0]      byte_reg;
  logic [BC_W-1:0] byte_cnt;
  logic [2:0]      bit_cnt;
  logic [2:0]      bit_nxt;

  assign bit_nxt = bit_cnt + 3'd1;

  // Pixel address is the byte index with the bit index appended below it.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [BC_W-1:0] b,
                                                 input logic [2:0]      k);
    return ADDR_W'({b, k});
  endfunction

  // Outputs are registered alongside the state so the RAM port never sees rx_* combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_reg <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 1'b0;
      start    <= 1'b0;
      loading  <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      start <= 1'b0;

      case (state)
        S_IDLE, S_WAIT: begin
          if (rx_rdy) begin
            byte_reg <= rx_data;
            bit_cnt  <= 3'd0;
            state    <= S_WRITE;
            wr_en    <= 1'b1;
            wr_addr  <= pix_addr(byte_cnt, 3'd0);
            wr_data  <= rx_data[0];
            loading  <= 1'b1;
          end
        end

        S_WRITE: begin
          if (bit_cnt == 3'd7) begin
            if (byte_cnt == LAST_BYTE) begin
              state   <= S_START;
              start   <= 1'b1;
              loading <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
              state    <= S_WAIT;
            end
          end else begin
            bit_cnt <= bit_nxt;
            wr_en   <= 1'b1;
            wr_addr <= pix_addr(byte_cnt, bit_nxt);
            wr_data <= byte_reg[bit_nxt];
          end
        end

        S_START: begin
          state    <= S_RUN;
          byte_cnt <= '0;
        end

        S_RUN: begin
          if (done) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase

      // A byte that cannot be taken is dropped and flagged until the next reset.
      if (rx_rdy && (state == S_WRITE || state == S_START || state == S_RUN))
        ovr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snn_rx_loader.sv
// Bench for snn_rx_loader: directed scenarios plus random traffic, checked every cycle
// against a queue-of-expected-pixel-writes model of the loader.
module tb_snn_rx_loader;

  localparam int unsigned NUM_BYTES = 98;
  localparam int unsigned ADDR_W    = 10;

  logic              clk     = 1'b0;
  logic              rst     = 1'b1;
  logic              rx_rdy  = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              done    = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              start;
  logic              loading;
  logic              ovr_err;

  snn_rx_loader #(.NUM_BYTES(NUM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_rdy  (rx_rdy),
    .rx_data (rx_data),
    .done    (done),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .loading (loading),
    .ovr_err (ovr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    bit data;
  } pix_t;

  pix_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_wr = 0;
  int   n_starts = 0;
  int   last_start_cyc = -1;
  bit   m_was_write = 1'b0;
  bit   m_start = 1'b0;
  bit   m_run = 1'b0;
  bit   m_load = 1'b0;
  bit   m_ovr = 1'b0;
  int   m_img = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: an accepted byte schedules 8 pixel writes for the next 8 cycles; the loader
  // is busy while writing, while start is out and while the core runs.
  task automatic model_edge(input bit r, input bit rdy, input bit [7:0] d, input bit dn);
    bit busy;
    if (r) begin
      exp_q.delete();
      m_img   = 0;
      m_run   = 1'b0;
      m_start = 1'b0;
      m_load  = 1'b0;
      m_ovr   = 1'b0;
      return;
    end
    busy = m_was_write || m_start || m_run;
    if (m_start) begin
      m_start = 1'b0;
      m_run   = 1'b1;
    end else if (m_run && dn) begin
      m_run = 1'b0;
    end
    if (m_was_write && exp_q.size() == 0 && m_img == int'(NUM_BYTES)) begin
      m_start = 1'b1;
      m_img   = 0;
      m_load  = 1'b0;
    end
    if (rdy) begin
      if (busy) begin
        m_ovr = 1'b1;
      end else begin
        for (int i = 0; i < 8; i++) begin
          pix_t p;
          p.addr = m_img * 8 + i;
          p.data = d[i];
          exp_q.push_back(p);
        end
        m_img++;
        m_load = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_we;
    exp_we = (exp_q.size() > 0);
    check("wr_en", int'(wr_en), int'(exp_we));
    if (wr_en === 1'b1) n_wr++;
    if (exp_we) begin
      pix_t p;
      p = exp_q.pop_front();
      check("wr_addr", int'(wr_addr), p.addr);
      check("wr_data", int'(wr_data), int'(p.data));
    end
    m_was_write = exp_we;
    check("start", int'(start), int'(m_start));
    check("loading", int'(loading), int'(m_load));
    check("ovr_err", int'(ovr_err), int'(m_ovr));
    if (start === 1'b1) begin
      n_starts++;
      last_start_cyc = cyc;
    end
  endtask

  // One clock: drive inputs, advance the model, then check outputs on the falling edge.
  task automatic tick(input bit r, input bit rdy, input bit [7:0] d, input bit dn);
    rst     = r;
    rx_rdy  = rdy;
    rx_data = d;
    done    = dn;
    model_edge(r, rdy, d, dn);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input bit dn);
    repeat (n) tick(1'b0, 1'b0, 8'h00, dn);
  endtask

  task automatic send(input bit [7:0] d, input int gap, input bit dn);
    tick(1'b0, 1'b1, d, dn);
    idle(gap, dn);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int rdy_cyc;
    int s0;
    int w0;
    rdy_cyc = 0;
    @(negedge clk);

    do_reset();
    do_reset();
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_start", int'(start), 0);
    check("rst_loading", int'(loading), 0);
    check("rst_ovr_err", int'(ovr_err), 0);

    // Single byte 0xA5 after reset
    w0 = n_wr;
    send(8'hA5, 9, 1'b0);
    check("a5_writes", n_wr - w0, 8);
    check("a5_loading", int'(loading), 1);
    check("a5_start", int'(start), 0);

    // Full image 0x00..0x61
    do_reset();
    w0 = n_wr;
    s0 = n_starts;
    for (int k = 0; k < int'(NUM_BYTES); k++) begin
      if (k == int'(NUM_BYTES) - 1) rdy_cyc = cyc;
      send(8'(k), 10 + int'($urandom_range(0, 4)), 1'b0);
    end
    check("img_writes", n_wr - w0, int'(NUM_BYTES) * 8);
    check("img_starts", n_starts - s0, 1);
    check("start_latency", last_start_cyc - rdy_cyc, 9);

    // Byte during RUN is dropped, then done returns to IDLE and the next image starts at 0
    w0 = n_wr;
    send(8'hFF, 2, 1'b0);
    check("run_no_write", n_wr - w0, 0);
    check("run_ovr", int'(ovr_err), 1);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    idle(2, 1'b0);
    send(8'($urandom), 10, 1'b0);
    check("post_run_writes", n_wr - w0, 8);

    // Overrun on the third cycle of a write burst
    do_reset();
    send(8'($urandom), 10, 1'b0);
    tick(1'b0, 1'b1, 8'($urandom), 1'b0);
    idle(2, 1'b0);
    tick(1'b0, 1'b1, 8'hFF, 1'b0);
    idle(8, 1'b0);
    check("mid_write_ovr", int'(ovr_err), 1);
    send(8'($urandom), 10, 1'b0);

    // Reset in the middle of byte 51's burst
    do_reset();
    repeat (50) send(8'($urandom), 10, 1'b0);
    tick(1'b0, 1'b1, 8'($urandom), 1'b0);
    tick(1'b0, 1'b1, 8'h3C, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    do_reset();
    check("mid_rst_wr_en", int'(wr_en), 0);
    check("mid_rst_addr", int'(wr_addr), 0);
    check("mid_rst_data", int'(wr_data), 0);
    check("mid_rst_loading", int'(loading), 0);
    check("mid_rst_ovr", int'(ovr_err), 0);
    send(8'($urandom), 10, 1'b0);

    // done held high through IDLE, WAIT and into RUN
    do_reset();
    idle(5, 1'b1);
    s0 = n_starts;
    for (int k = 0; k < int'(NUM_BYTES); k++) send(8'($urandom), 10, 1'b1);
    idle(1, 1'b1);
    check("done_starts", n_starts - s0, 1);
    send(8'($urandom), 10, 1'b0);
    check("done_no_ovr", int'(ovr_err), 0);

    // Random traffic with overruns, stray done pulses and occasional resets
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 5) == 0,
           8'($urandom), $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
